// File: rtl/gardner_timing_loop_if.sv
// Signal bundle between the oversampled I/Q front-end, the Gardner detector and the demapper.
// The timing loop takes the slave side; the feeding environment takes the master side.
interface gardner_timing_loop_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_I;
  logic [WIDTH-1:0] in_Q;
  logic [WIDTH-1:0] error_n;
  logic             ted_valid;
  logic [WIDTH-1:0] I;
  logic [WIDTH-1:0] I_d16;
  logic [WIDTH-1:0] I_d32;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_d16;
  logic [WIDTH-1:0] Q_d32;
  logic             sym_valid;
  logic [WIDTH-1:0] sym_I;
  logic [WIDTH-1:0] sym_Q;
  logic             adj_skip;
  logic             adj_stuff;

  modport master (
    output in_valid, in_I, in_Q, error_n,
    input  ted_valid, I, I_d16, I_d32, Q, Q_d16, Q_d32,
    input  sym_valid, sym_I, sym_Q, adj_skip, adj_stuff
  );

  modport slave (
    input  in_valid, in_I, in_Q, error_n,
    output ted_valid, I, I_d16, I_d32, Q, Q_d16, Q_d32,
    output sym_valid, sym_I, sym_Q, adj_skip, adj_stuff
  );
endinterface

// File: rtl/gardner_timing_loop.sv
// Symbol-timing loop around a Gardner TED: delay line, symbol strobe, PI loop filter and
// sample skip/stuff retiming of the strobe.
module gardner_timing_loop #(
  parameter int WIDTH      = 16,
  parameter int SPS        = 32,
  parameter int KP_SHIFT   = 4,
  parameter int KI_SHIFT   = 10,
  parameter int ACC_WIDTH  = 24,
  parameter int ADJ_THRESH = 4096
) (
  input logic                  clk,
  input logic                  rst,
  gardner_timing_loop_if.slave bus
);
  localparam int FILL_W = $clog2(SPS + 2);
  localparam int PH_W   = $clog2(SPS + 1);
  localparam logic signed [ACC_WIDTH:0] L_SAT_POS = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] L_SAT_NEG = -L_SAT_POS;
  localparam logic signed [ACC_WIDTH-1:0] L_THRESH = ACC_WIDTH'(ADJ_THRESH);

  typedef enum logic [1:0] {PendNone = 2'd0, PendSkip = 2'd1, PendStuff = 2'd2} pend_e;

  logic [WIDTH-1:0]            r_dl_i [SPS+1];
  logic [WIDTH-1:0]            r_dl_q [SPS+1];
  logic [FILL_W-1:0]           r_fill;
  logic [PH_W-1:0]             r_ph, w_ph_nxt, w_wrap_pt;
  pend_e                       r_pend, w_pend_nxt;
  logic signed [ACC_WIDTH-1:0] r_integ, r_pacc, w_integ_nxt, w_pacc_nxt;
  logic signed [ACC_WIDTH-1:0] w_err_ext, w_err_ki, w_err_kp, w_integ_sat, w_ctrl;
  logic signed [ACC_WIDTH:0]   w_integ_sum;
  logic                        r_err_en, r_eval, w_full, w_strobe;
  logic                        r_ted_valid, r_adj_skip, r_adj_stuff;
  logic [WIDTH-1:0]            r_i0, r_i16, r_i32, r_q0, r_q16, r_q32;

  // Phase is held at 0 while filling; the sample that fills the line is the first strobe.
  always_comb begin
    w_full = (r_fill == FILL_W'(SPS + 1));
    case (r_pend)
      PendSkip:  w_wrap_pt = PH_W'(SPS - 2);
      PendStuff: w_wrap_pt = PH_W'(SPS);
      default:   w_wrap_pt = PH_W'(SPS - 1);
    endcase
    w_strobe = bus.in_valid && (w_full ? (r_ph >= w_wrap_pt) : (r_fill == FILL_W'(SPS)));
    w_ph_nxt = r_ph;
    if (bus.in_valid && w_full) begin
      w_ph_nxt = (r_ph >= w_wrap_pt) ? '0 : r_ph + 1'b1;
    end
  end

  always_comb begin
    w_err_ext   = {{(ACC_WIDTH-WIDTH){bus.error_n[WIDTH-1]}}, bus.error_n};
    w_err_ki    = w_err_ext >>> KI_SHIFT;
    w_err_kp    = w_err_ext >>> KP_SHIFT;
    w_integ_sum = {r_integ[ACC_WIDTH-1], r_integ} + {w_err_ki[ACC_WIDTH-1], w_err_ki};
    if (w_integ_sum > L_SAT_POS) begin
      w_integ_sat = L_SAT_POS[ACC_WIDTH-1:0];
    end else if (w_integ_sum < L_SAT_NEG) begin
      w_integ_sat = L_SAT_NEG[ACC_WIDTH-1:0];
    end else begin
      w_integ_sat = w_integ_sum[ACC_WIDTH-1:0];
    end
    // Proportional path uses the freshly updated integrator.
    w_ctrl = w_err_kp + w_integ_sat;

    w_integ_nxt = r_integ;
    w_pacc_nxt  = r_pacc;
    w_pend_nxt  = r_pend;
    if (w_strobe) begin
      w_pend_nxt = PendNone;
    end
    if (r_err_en) begin
      w_integ_nxt = w_integ_sat;
      w_pacc_nxt  = r_pacc + w_ctrl;
    end else if (r_eval && r_pend == PendNone) begin
      if (r_pacc >= L_THRESH) begin
        w_pend_nxt = PendSkip;
        w_pacc_nxt = r_pacc - L_THRESH;
      end else if (r_pacc <= -L_THRESH) begin
        w_pend_nxt = PendStuff;
        w_pacc_nxt = r_pacc + L_THRESH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= SPS; k++) begin
        r_dl_i[k] <= '0;
        r_dl_q[k] <= '0;
      end
      r_fill      <= '0;
      r_ph        <= '0;
      r_pend      <= PendNone;
      r_integ     <= '0;
      r_pacc      <= '0;
      r_err_en    <= 1'b0;
      r_eval      <= 1'b0;
      r_ted_valid <= 1'b0;
      r_adj_skip  <= 1'b0;
      r_adj_stuff <= 1'b0;
      r_i0        <= '0;
      r_i16       <= '0;
      r_i32       <= '0;
      r_q0        <= '0;
      r_q16       <= '0;
      r_q32       <= '0;
    end else begin
      if (bus.in_valid) begin
        r_dl_i[0] <= bus.in_I;
        r_dl_q[0] <= bus.in_Q;
        for (int k = 1; k <= SPS; k++) begin
          r_dl_i[k] <= r_dl_i[k-1];
          r_dl_q[k] <= r_dl_q[k-1];
        end
        if (!w_full) r_fill <= r_fill + 1'b1;
      end
      r_ph        <= w_ph_nxt;
      r_pend      <= w_pend_nxt;
      r_integ     <= w_integ_nxt;
      r_pacc      <= w_pacc_nxt;
      r_err_en    <= r_ted_valid;
      r_eval      <= r_err_en;
      r_ted_valid <= w_strobe;
      r_adj_skip  <= w_strobe && (r_pend == PendSkip);
      r_adj_stuff <= w_strobe && (r_pend == PendStuff);
      // Taps are the post-shift line contents, taken one stage early from the pre-shift line.
      if (w_strobe) begin
        r_i0  <= bus.in_I;
        r_i16 <= r_dl_i[SPS/2-1];
        r_i32 <= r_dl_i[SPS-1];
        r_q0  <= bus.in_Q;
        r_q16 <= r_dl_q[SPS/2-1];
        r_q32 <= r_dl_q[SPS-1];
      end
    end
  end

  assign bus.ted_valid = r_ted_valid;
  assign bus.sym_valid = r_ted_valid;
  assign bus.I         = r_i0;
  assign bus.I_d16     = r_i16;
  assign bus.I_d32     = r_i32;
  assign bus.Q         = r_q0;
  assign bus.Q_d16     = r_q16;
  assign bus.Q_d32     = r_q32;
  assign bus.sym_I     = r_i0;
  assign bus.sym_Q     = r_q0;
  assign bus.adj_skip  = r_adj_skip;
  assign bus.adj_stuff = r_adj_stuff;
endmodule

// File: tb/tb_gardner_timing_loop.sv
// Directed bench for gardner_timing_loop: symbol-level loop model feeds a scoreboard of
// expected strobes; a negedge monitor pops and checks taps, timing and adjust pulses.
module tb_gardner_timing_loop;
  localparam int WIDTH  = 16;
  localparam int SPS    = 32;
  localparam int KP     = 4;
  localparam int KI     = 10;
  localparam int ACCW   = 24;
  localparam int THRESH = 4096;
  localparam int SATMAX = (1 << (ACCW - 1)) - 1;
  localparam logic [15:0] POISON = 16'h7FFF;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] i0, i16, i32, q0, q16, q32;
    logic        skip, stuff;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gardner_timing_loop_if #(.WIDTH(WIDTH)) bus ();

  gardner_timing_loop #(
    .WIDTH(WIDTH), .SPS(SPS), .KP_SHIFT(KP), .KI_SHIFT(KI),
    .ACC_WIDTH(ACCW), .ADJ_THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned        vectors = 0;
  int unsigned        miscompares = 0;
  int unsigned        cyc = 0;
  exp_t               sbq[$];
  exp_t               hold;
  logic signed [15:0] err_val = '0;
  logic [15:0]        g = '0;
  logic               tv_prev = 1'b0;
  int                 m_integ, m_pacc, m_pend, m_fill, m_sym;

  always @(posedge clk) cyc <= cyc + 1;

  // Detector stand-in: valid error only in the cycle after ted_valid, garbage otherwise.
  always @(posedge clk) begin
    #1;
    bus.error_n = tv_prev ? err_val : POISON;
    tv_prev = (bus.ted_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold = '0;
    end else if (bus.ted_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 32'(bus.ted_valid), 32'd0);
      end else begin
        hold = sbq.pop_front();
        chk("strobe_cycle", cyc, hold.cyc);
        chk("sym_valid", 32'(bus.sym_valid), 32'd1);
        chk("I", 32'(bus.I), 32'(hold.i0));
        chk("I_d16", 32'(bus.I_d16), 32'(hold.i16));
        chk("I_d32", 32'(bus.I_d32), 32'(hold.i32));
        chk("Q", 32'(bus.Q), 32'(hold.q0));
        chk("Q_d16", 32'(bus.Q_d16), 32'(hold.q16));
        chk("Q_d32", 32'(bus.Q_d32), 32'(hold.q32));
        chk("sym_I", 32'(bus.sym_I), 32'(hold.i0));
        chk("sym_Q", 32'(bus.sym_Q), 32'(hold.q0));
        chk("adj_skip", 32'(bus.adj_skip), 32'(hold.skip));
        chk("adj_stuff", 32'(bus.adj_stuff), 32'(hold.stuff));
      end
    end else begin
      chk("idle_ted_valid", 32'(bus.ted_valid), 32'd0);
      chk("idle_sym_valid", 32'(bus.sym_valid), 32'd0);
      chk("idle_adj", {30'd0, bus.adj_skip, bus.adj_stuff}, 32'd0);
      chk("hold_I", 32'(bus.I), 32'(hold.i0));
      chk("hold_I_d32", 32'(bus.I_d32), 32'(hold.i32));
      chk("hold_Q_d16", 32'(bus.Q_d16), 32'(hold.q16));
    end
  end

  task automatic model_clear();
    m_integ = 0; m_pacc = 0; m_pend = 0; m_fill = 0; m_sym = 0;
  endtask

  task automatic model_filter(input logic signed [15:0] e);
    m_integ = m_integ + (int'(e) >>> KI);
    if (m_integ > SATMAX) m_integ = SATMAX;
    if (m_integ < -SATMAX) m_integ = -SATMAX;
    m_pacc = m_pacc + (int'(e) >>> KP) + m_integ;
    if (m_pend == 0) begin
      if (m_pacc >= THRESH) begin
        m_pend = 1;
        m_pacc = m_pacc - THRESH;
      end else if (m_pacc <= -THRESH) begin
        m_pend = -1;
        m_pacc = m_pacc + THRESH;
      end
    end
  endtask

  task automatic model_sample();
    exp_t e;
    bit   strobe = 1'b0;
    int   period;
    if (m_fill < SPS + 1) begin
      m_fill++;
      strobe = (m_fill == SPS + 1);
    end else begin
      period = (m_pend == 1) ? SPS - 1 : (m_pend == -1) ? SPS + 1 : SPS;
      m_sym++;
      strobe = (m_sym == period);
    end
    if (strobe) begin
      e.cyc   = cyc + 1;
      e.i0    = g;
      e.i16   = 16'(g - 16'd16);
      e.i32   = 16'(g - 16'd32);
      e.q0    = g ^ 16'hA5A5;
      e.q16   = 16'(g - 16'd16) ^ 16'hA5A5;
      e.q32   = 16'(g - 16'd32) ^ 16'hA5A5;
      e.skip  = (m_pend == 1);
      e.stuff = (m_pend == -1);
      sbq.push_back(e);
      m_pend = 0;
      m_sym  = 0;
      model_filter(err_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v);
    tick();
    bus.in_valid = v;
    if (v) begin
      g = g + 16'd1;
      bus.in_I = g;
      bus.in_Q = g ^ 16'hA5A5;
      model_sample();
    end else begin
      bus.in_I = 16'($urandom);
      bus.in_Q = 16'($urandom);
    end
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      repeat (gap) step(1'b0);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_ted_valid", 32'(bus.ted_valid), 32'd0);
    chk("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("rst_taps_I", {bus.I, bus.I_d16}, 32'd0);
    chk("rst_taps_mix", {bus.I_d32, bus.Q}, 32'd0);
    chk("rst_taps_Q", {bus.Q_d16, bus.Q_d32}, 32'd0);
    chk("rst_sym", {bus.sym_I, bus.sym_Q}, 32'd0);
    chk("rst_adj", {30'd0, bus.adj_skip, bus.adj_stuff}, 32'd0);
    chk("rst_sbq_empty", sbq.size(), 32'd0);
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_I     = '0;
    bus.in_Q     = '0;
    model_clear();
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;

    // Fill then steady nominal: strobes at samples 33, 65, 97, 129.
    err_val = 16'sd0;
    run(129, 0);

    // Skip: crossing on symbol 4, 31-sample symbol with adj_skip, then nominal again.
    do_reset();
    err_val = 16'sd16384;
    run(192, 0);

    // Reset mid-symbol with a skip pending, 20 samples past the strobe.
    do_reset();
    err_val = 16'sd16384;
    run(149, 0);
    do_reset();

    // Stuff: mirror case, 33-sample symbol with adj_stuff.
    err_val = -16'sd16384;
    run(194, 0);

    // in_valid every 3rd clock: strobes stretch to 96 clocks.
    do_reset();
    err_val = 16'sd0;
    run(97, 2);
    repeat (5) step(1'b0);

    chk("sbq_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
